// File: rtl/seq_shift_unit.sv
// ---------------------------------------------------------------------------
// seq_shift_unit
//
// Multi-cycle barrel-shift replacement. An operand is latched on a start
// request and shifted by at most STEP bits per clock until the requested
// amount has been applied. Only the finished value ever reaches data_o.
//
// Parameters
//   WIDTH    data width (power of 2, >= 8)
//   STEP     maximum bits shifted per cycle (power of 2, 1 .. WIDTH/2)
//   SHAMT_W  derived shift-amount width, log2(WIDTH)
//
// Ports
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   start_i   begin an operation (honoured in IDLE only)
//   mode_i    00 SLL, 01 SRL, 10 SRA, 11 ROR
//   shamt_i   unsigned shift amount
//   data_i    operand
//   data_o    registered final result
//   busy_o    high while an operation is in flight (SHIFT or DONE)
//   done_o    one-cycle pulse while the result is first presented
// ---------------------------------------------------------------------------
module seq_shift_unit #(
  parameter  int WIDTH   = 32,
  parameter  int STEP    = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  localparam logic [SHAMT_W-1:0] STEP_C  = SHAMT_W'(STEP);
  localparam logic [SHAMT_W:0]   WIDTH_C = (SHAMT_W + 1)'(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] remaining;
  logic [1:0]         mode_r;

  logic [SHAMT_W-1:0] step_n;
  logic [SHAMT_W:0]   rot_back;
  logic [WIDTH-1:0]   acc_next;

  // Bits to move this cycle: a full STEP, or whatever is left on the last
  // partial step so the total never overshoots the requested amount.
  always_comb begin
    step_n   = (remaining < STEP_C) ? remaining : STEP_C;
    rot_back = WIDTH_C - {1'b0, step_n};
  end

  // One step of the latched shift. step_n is never zero while in SHIFT,
  // so the rotate's left-shift amount stays below WIDTH.
  always_comb begin
    acc_next = acc;
    case (mode_r)
      MODE_SLL: acc_next = acc << step_n;
      MODE_SRL: acc_next = acc >> step_n;
      MODE_SRA: acc_next = WIDTH'($signed(acc) >>> step_n);
      MODE_ROR: acc_next = (acc >> step_n) | (acc << rot_back);
      default:  acc_next = acc;
    endcase
  end

  // Control FSM with registered outputs. data_o is written only when
  // entering DONE, so intermediate accumulator values stay hidden.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      mode_r    <= MODE_SLL;
      data_o    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            acc       <= data_i;
            remaining <= shamt_i;
            mode_r    <= mode_i;
            busy_o    <= 1'b1;
            if (shamt_i == '0) begin
              // Nothing to shift: present the operand straight away.
              state  <= DONE;
              data_o <= data_i;
              done_o <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          acc       <= acc_next;
          remaining <= remaining - step_n;
          if (remaining == step_n) begin
            state  <= DONE;
            data_o <= acc_next;
            done_o <= 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width; it is a power of 2 and at least 8.
REQ-002 The block SHALL have parameter STEP, default 1, giving the maximum bits shifted per cycle; it is a power of 2 from 1 to WIDTH/2.
REQ-003 The block SHALL use the derived local constant SHAMT_W = log2(WIDTH) as the shift-amount width; it is not user-settable.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start_i, input, 1 bit: request to begin an operation.
REQ-007 The block SHALL have port mode_i, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-008 The block SHALL have port shamt_i, input, SHAMT_W bits: unsigned shift amount, zero-extended internally.
REQ-009 The block SHALL have port data_i, input, WIDTH bits: the operand.
REQ-010 The block SHALL have port data_o, output, WIDTH bits: the registered result.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-012 The block SHALL have port done_o, output, 1 bit: a one-cycle pulse marking a valid result.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with start_i=1 at a rising edge, the block SHALL latch data_i into the accumulator, shamt_i into the remaining counter and mode_i into the mode register.
REQ-015 On that start edge, the FSM SHALL go to DONE if shamt_i=0, else to SHIFT.
REQ-016 In SHIFT, each edge SHALL shift the accumulator by n = min(STEP, remaining) in the latched mode and decrement remaining by n.
REQ-017 The FSM SHALL go from SHIFT to DONE on the edge where remaining reaches 0.
REQ-018 SLL and SRL SHALL zero-fill the vacated bits.
REQ-019 SRA SHALL fill the vacated bits with the accumulator MSB.
REQ-020 ROR SHALL feed the bits shifted out of bit 0 back in at bit WIDTH-1.
REQ-021 On entry to DONE, data_o SHALL load the final accumulator value; data_o SHALL hold that value until the next entry to DONE.
REQ-022 data_o SHALL never show intermediate accumulator values.
REQ-023 done_o SHALL be high for exactly the one cycle the FSM is in DONE; DONE SHALL always go to IDLE on the next edge.
REQ-024 Latency SHALL be ceil(shamt/STEP)+1 edges from the start edge to the edge that leaves DONE.
REQ-025 done_o SHALL be visible in the cycle following edge ceil(shamt/STEP) after the start edge; shamt=0 gives done_o in the cycle right after the start edge.
REQ-026 start_i SHALL be ignored in SHIFT and DONE, and mode_i/shamt_i/data_i changes SHALL not affect an operation in progress.
REQ-027 Throughput SHALL be one operation per ceil(shamt/STEP)+2 cycles; no back-to-back start in the DONE cycle.
REQ-028 The final partial step (remaining < STEP) SHALL shift exactly the remaining bits.
REQ-029 The result SHALL equal the single-cycle shift of the operand by shamt in every mode.

Reset
REQ-030 With rst_i=1 at a rising edge, the block SHALL set state to IDLE and clear the accumulator, remaining counter and mode register.
REQ-031 With rst_i=1 at a rising edge, the block SHALL drive data_o=0, busy_o=0 and done_o=0 from the following cycle.
REQ-032 rst_i SHALL take priority over start_i in the same cycle.
REQ-033 Reset mid-operation (SHIFT or DONE) SHALL abort the operation with no done_o pulse, and data_o SHALL read 0.

Verification
REQ-034 The bench SHALL cover: WIDTH=32, STEP=1, SRA, data 0x80000000, shamt 4 -> done_o after 4 cycles, data_o=0xF8000000; repeat with SRL -> 0x08000000.
REQ-035 The bench SHALL cover: STEP=1, SLL, data 0x00000001, shamt 31 -> busy_o high 32 cycles, done_o once, data_o=0x80000000; STEP=4 -> done_o after 8 cycles, same result.
REQ-036 The bench SHALL cover: ROR, data 0x0000000F, shamt 4, STEP=4 -> done_o after 1 shift cycle, data_o=0xF0000000.
REQ-037 The bench SHALL cover: shamt 0, any mode, data 0x12345678 -> done_o in the cycle after start, data_o=0x12345678.
REQ-038 The bench SHALL cover: start, then change data_i and pulse start_i during SHIFT -> result matches the original operand and only one done_o pulse occurs.
REQ-039 The bench SHALL cover: rst_i asserted 3 cycles into SLL by 20 -> next cycle busy_o=0, data_o=0, no done_o; a new start then completes normally.
